// File: rtl/contador_paquetes.sv
// contador_paquetes: per-channel word counter behind the routing FIFO fabric.
// Counts words popped from output FIFOs 4..7, tracks fabric activity with a
// small FSM, and serves single-cycle-latency reads of a selected channel count
// while the fabric is idle.
// Optional build macro: COUNTER_CLR_ON_READ_EN (accepted reads clear the count).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_RESET  | just left reset; counters zero, valid_in dropped
// ST_INIT   | init asserted; counters held at zero, valid_in dropped
// ST_IDLE   | fabric idle; counting enabled, reads accepted
// ST_ACTIVE | fabric busy; counting enabled, reads dropped

module contador_paquetes #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 5,
  parameter int IDX_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 idle_in,
  input  logic [NUM_CH-1:0]    valid_in,
  input  logic                 req,
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [CNT_WIDTH-1:0] counter_out,
  output logic                 valid_out,
  output logic [1:0]           state_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt [NUM_CH];
  logic                 rd_accept;
  logic                 rd_in_range;
  logic                 any_valid;

  assign any_valid   = |valid_in;
  assign rd_accept   = req && (state == ST_IDLE);
  assign rd_in_range = 32'(idx) < NUM_CH;
  assign state_out   = state;

  // Fabric activity FSM; init wins over every state except reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RESET;
    end else if (init) begin
      state <= ST_INIT;
    end else begin
      case (state)
        ST_RESET:  state <= ST_INIT;
        ST_INIT:   state <= ST_IDLE;
        ST_IDLE:   if (!idle_in || any_valid) state <= ST_ACTIVE;
        ST_ACTIVE: if (idle_in && !any_valid) state <= ST_IDLE;
        default:   state <= ST_RESET;
      endcase
    end
  end

  // Per-channel counters; pops seen outside IDLE/ACTIVE are discarded.
  always_ff @(posedge clk) begin
    if (reset || state == ST_RESET || state == ST_INIT) begin
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (valid_in[i]) cnt[i] <= cnt[i] + CNT_WIDTH'(1);
      end
`ifdef COUNTER_CLR_ON_READ_EN
      // Clear wins over the increment, but a same-cycle pop still counts once.
      if (rd_accept && rd_in_range) begin
        cnt[idx] <= {{(CNT_WIDTH-1){1'b0}}, valid_in[idx]};
      end
`endif
    end
  end

  // Read port: returns the pre-update count one clock after an accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_out <= '0;
      valid_out   <= 1'b0;
    end else if (rd_accept) begin
      counter_out <= rd_in_range ? cnt[idx] : '0;
      valid_out   <= 1'b1;
    end else begin
      counter_out <= '0;
      valid_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_contador_paquetes.sv
// Self-checking bench for contador_paquetes: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_contador_paquetes;

  logic       clk = 1'b0;
  logic       reset, init, idle_in, req;
  logic [3:0] valid_in;
  logic [1:0] idx;
  logic [4:0] counter_out;
  logic       valid_out;
  logic [1:0] state_out;

  int checks = 0;
  int errors = 0;

  // behavioural model
  int         m_state;
  int         m_cnt [4];
  logic [4:0] m_out;
  logic       m_valid;

  always #5 clk = ~clk;

  contador_paquetes dut (
    .clk(clk), .reset(reset), .init(init), .idle_in(idle_in),
    .valid_in(valid_in), .req(req), .idx(idx),
    .counter_out(counter_out), .valid_out(valid_out), .state_out(state_out)
  );

  // Apply one cycle of inputs, advance the model across the edge, settle.
  task automatic drive(input logic r, input logic in, input logic idl,
                       input logic [3:0] v, input logic rq, input logic [1:0] ix);
    bit accepted;
    reset = r; init = in; idle_in = idl; valid_in = v; req = rq; idx = ix;
    @(posedge clk);
    if (r) begin
      m_state = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_out = 0; m_valid = 0;
    end else begin
      accepted = rq && (m_state == 2);
      m_valid  = accepted;
      m_out    = accepted ? 5'(m_cnt[ix]) : 5'd0;
      if (m_state <= 1) foreach (m_cnt[i]) m_cnt[i] = 0;
      else foreach (m_cnt[i]) m_cnt[i] = (m_cnt[i] + int'(v[i])) % 32;
`ifdef COUNTER_CLR_ON_READ_EN
      if (accepted) m_cnt[ix] = int'(v[ix]);
`endif
      if (in) m_state = 1;
      else if (m_state == 0) m_state = 1;
      else if (m_state == 1) m_state = 2;
      else if (m_state == 2) m_state = (!idl || v != 0) ? 3 : 2;
      else m_state = (idl && v == 0) ? 2 : 3;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1, 1, 1, 4'hF, 1, 2'd1);
      checks++;
      if (state_out !== 2'd0 || counter_out !== 5'd0 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got st=%0d out=%0d v=%0b want st=0 out=0 v=0",
                 state_out, counter_out, valid_out);
      end
    end
    drive(0, 1, 1, 4'h0, 1, 2'd0);
    checks++;
    if (state_out !== 2'd1 || counter_out !== 5'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_init got st=%0d out=%0d v=%0b want st=1 out=0 v=0",
               state_out, counter_out, valid_out);
    end
  endtask

  task automatic test_count_all();
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    checks++;
    if (state_out !== 2'd2) begin
      errors++; $display("FAIL enter_idle got st=%0d want 2", state_out);
    end
    for (int c = 0; c < 8; c++) drive(0, 0, 1, 4'hF, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 4'h0, 1, 2'(i));
      checks++;
      if (counter_out !== 5'd8 || valid_out !== 1'b1 || counter_out !== m_out) begin
        errors++;
        $display("FAIL count_all[%0d] got out=%0d v=%0b want out=8 v=1", i, counter_out, valid_out);
      end
    end
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    checks++;
    if (valid_out !== 1'b0 || counter_out !== 5'd0) begin
      errors++; $display("FAIL no_req got out=%0d v=%0b want out=0 v=0", counter_out, valid_out);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] want;
    drive(0, 1, 1, 4'h0, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    for (int c = 0; c < 33; c++) drive(0, 0, 1, 4'h4, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      want = (i == 2) ? 5'd1 : 5'd0;
      drive(0, 0, 1, 4'h0, 1, 2'(i));
      checks++;
      if (counter_out !== want || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL wrap[%0d] got out=%0d v=%0b want out=%0d v=1", i, counter_out, valid_out, want);
      end
    end
  endtask

  task automatic test_active_read();
    drive(0, 1, 1, 4'h0, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    for (int c = 0; c < 3; c++) drive(0, 0, 1, 4'h8, 0, 2'd0);
    drive(0, 0, 0, 4'h0, 1, 2'd3);
    drive(0, 0, 0, 4'h0, 1, 2'd3);
    checks++;
    if (state_out !== 2'd3 || valid_out !== 1'b0 || counter_out !== 5'd0) begin
      errors++;
      $display("FAIL active_read got st=%0d out=%0d v=%0b want st=3 out=0 v=0",
               state_out, counter_out, valid_out);
    end
    drive(0, 0, 1, 4'h0, 0, 2'd3);
    drive(0, 0, 1, 4'h0, 1, 2'd3);
    checks++;
    if (counter_out !== 5'd3 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL idle_read got out=%0d v=%0b want out=3 v=1", counter_out, valid_out);
    end
  endtask

  task automatic test_init_mid();
    for (int c = 0; c < 4; c++) drive(0, 0, 0, 4'hF, 0, 2'd0);
    drive(0, 1, 0, 4'hF, 0, 2'd0);
    checks++;
    if (state_out !== 2'd1) begin
      errors++; $display("FAIL init_mid got st=%0d want 1", state_out);
    end
    for (int c = 0; c < 3; c++) drive(0, 1, 0, 4'hF, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 4'h0, 1, 2'(i));
      checks++;
      if (counter_out !== 5'd0 || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL post_init[%0d] got out=%0d v=%0b want out=0 v=1", i, counter_out, valid_out);
      end
    end
  endtask

`ifdef COUNTER_CLR_ON_READ_EN
  task automatic test_clr_on_read();
    drive(0, 1, 1, 4'h0, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    for (int c = 0; c < 5; c++) drive(0, 0, 1, 4'h2, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 1, 2'd1);
    checks++;
    if (counter_out !== 5'd5 || valid_out !== 1'b1) begin
      errors++; $display("FAIL clr_first got out=%0d v=%0b want out=5 v=1", counter_out, valid_out);
    end
    drive(0, 0, 1, 4'h2, 1, 2'd1);
    checks++;
    if (counter_out !== 5'd0 || valid_out !== 1'b1) begin
      errors++; $display("FAIL clr_second got out=%0d v=%0b want out=0 v=1", counter_out, valid_out);
    end
    drive(0, 0, 1, 4'h0, 0, 2'd0);
    drive(0, 0, 1, 4'h0, 1, 2'd1);
    checks++;
    if (counter_out !== 5'd1 || valid_out !== 1'b1) begin
      errors++; $display("FAIL clr_with_pop got out=%0d v=%0b want out=1 v=1", counter_out, valid_out);
    end
  endtask
`endif

  task automatic test_random();
    logic r, in, idl, rq;
    logic [3:0] v;
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 79) == 0);
      in  = ($urandom_range(0, 39) == 0);
      idl = ($urandom_range(0, 3) != 0);
      v   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      rq  = ($urandom_range(0, 1) == 1);
      drive(r, in, idl, v, rq, 2'($urandom));
      checks++;
      if (state_out !== 2'(m_state) || counter_out !== m_out || valid_out !== m_valid) begin
        errors++;
        $display("FAIL random[%0d] got st=%0d out=%0d v=%0b want st=%0d out=%0d v=%0b",
                 c, state_out, counter_out, valid_out, m_state, m_out, m_valid);
      end
    end
  endtask

  initial begin
    reset = 1; init = 1; idle_in = 1; valid_in = 0; req = 0; idx = 0;
    m_state = 0; m_out = 0; m_valid = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    @(negedge clk);
    test_reset();
    test_count_all();
    test_wrap();
    test_active_read();
    test_init_mid();
`ifdef COUNTER_CLR_ON_READ_EN
    test_clr_on_read();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
